// File: rtl/tmds_mode_switch.sv
// ----------------------------------------------------------------------------
// tmds_mode_switch
//
// Frame-aligned, glitch-free selector between the free-running HDMI and DVI
// TMDS encoder outputs. A change of mode_req must be seen on STABLE_FRAMES
// consecutive frame starts before the routed source changes. The change only
// takes effect on a frame start. It is followed by MUTE_FRAMES whole frames of
// BLANK_SYMBOL so the sink can re-lock cleanly.
//
// Optional feature macro: TMDS_MODE_SWITCH_COUNT_EN
//   When defined, adds the switch_count port: a saturating count of completed
//   switches.
//
// Ports
//   clk_pixel      in   pixel clock (only clock)
//   reset_n        in   synchronous active-low reset
//   mode_req       in   requested mode, 1 = DVI
//   frame_start    in   one-cycle pulse at the first pixel of a frame
//   tmds_hdmi      in   HDMI encoder symbols, 10 bits per channel
//   tmds_dvi       in   DVI encoder symbols, 10 bits per channel
//   tmds_channels  out  registered output symbols, 10 bits per channel
//   active_mode    out  mode currently routed, 1 = DVI
//   dbg_state      out  FSM state (0 ACTIVE, 1 PENDING, 2 MUTE) for debug
//   switching      out  high while a change is pending or muting
//   switch_count   out  completed switches, saturating at 255 (macro only)
// ----------------------------------------------------------------------------
module tmds_mode_switch #(
    parameter int          NUM_CHANNELS  = 3,
    parameter int          STABLE_FRAMES = 2,
    parameter int          MUTE_FRAMES   = 1,
    parameter bit          RESET_MODE    = 1'b0,
    parameter logic [9:0]  BLANK_SYMBOL  = 10'b1101010100
) (
    input  logic                      clk_pixel,
    input  logic                      reset_n,
    input  logic                      mode_req,
    input  logic                      frame_start,
    input  logic [10*NUM_CHANNELS-1:0] tmds_hdmi,
    input  logic [10*NUM_CHANNELS-1:0] tmds_dvi,
    output logic [10*NUM_CHANNELS-1:0] tmds_channels,
    output logic                      active_mode,
    output logic [1:0]                dbg_state,
    output logic                      switching
`ifdef TMDS_MODE_SWITCH_COUNT_EN
    ,
    output logic [7:0]                switch_count
`endif
);

    localparam int SW = $clog2(STABLE_FRAMES + 1);
    // A zero-width counter is illegal; MUTE_FRAMES=0 keeps a 1-bit counter
    // that is never loaded with anything but zero.
    localparam int MW = (MUTE_FRAMES > 0) ? $clog2(MUTE_FRAMES + 1) : 1;
    localparam int DW = 10 * NUM_CHANNELS;

    typedef enum logic [1:0] {
        ST_ACTIVE  = 2'd0,
        ST_PENDING = 2'd1,
        ST_MUTE    = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            active_mode_q, active_mode_d;
    logic            target_q, target_d;
    logic [SW-1:0]   stable_cnt_q, stable_cnt_d;
    logic [MW-1:0]   mute_cnt_q, mute_cnt_d;
    logic [DW-1:0]   tmds_q, tmds_d;
    logic [SW-1:0]   new_cnt;
    logic            do_switch;
    logic [DW-1:0]   blank_all;

    assign blank_all = {NUM_CHANNELS{BLANK_SYMBOL}};

    always_comb begin
        state_d       = state_q;
        active_mode_d = active_mode_q;
        target_d      = target_q;
        mute_cnt_d    = mute_cnt_q;
        new_cnt       = stable_cnt_q;
        do_switch     = 1'b0;

        case (state_q)
            ST_ACTIVE: begin
                if (frame_start && (mode_req != active_mode_q)) begin
                    target_d = mode_req;
                    new_cnt  = SW'(1);
                    state_d  = ST_PENDING;
                    // With a one-frame debounce the first sighting is enough.
                    if (STABLE_FRAMES <= 1) begin
                        do_switch = 1'b1;
                    end
                end
            end
            ST_PENDING: begin
                if (frame_start) begin
                    if (mode_req == active_mode_q) begin
                        state_d = ST_ACTIVE;
                        new_cnt = '0;
                    end else if (mode_req != target_q) begin
                        // Only reachable if the mode is ever widened.
                        target_d = mode_req;
                        new_cnt  = SW'(1);
                        if (STABLE_FRAMES <= 1) begin
                            do_switch = 1'b1;
                        end
                    end else begin
                        new_cnt = stable_cnt_q + SW'(1);
                        if (int'(new_cnt) >= STABLE_FRAMES) begin
                            do_switch = 1'b1;
                        end
                    end
                end
            end
            ST_MUTE: begin
                // mode_req is deliberately ignored until back in ACTIVE.
                if (frame_start) begin
                    if (mute_cnt_q <= MW'(1)) begin
                        mute_cnt_d = '0;
                        state_d    = ST_ACTIVE;
                    end else begin
                        mute_cnt_d = mute_cnt_q - MW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_ACTIVE;
                new_cnt = '0;
            end
        endcase

        stable_cnt_d = new_cnt;

        if (do_switch) begin
            active_mode_d = target_d;
            stable_cnt_d  = '0;
            if (MUTE_FRAMES > 0) begin
                state_d    = ST_MUTE;
                mute_cnt_d = MW'(MUTE_FRAMES);
            end else begin
                state_d = ST_ACTIVE;
            end
        end

        // Selection uses the next state so a decision on frame_start in
        // cycle N is visible at the registered output in cycle N+1.
        if (state_d == ST_MUTE) begin
            tmds_d = blank_all;
        end else if (active_mode_d) begin
            tmds_d = tmds_dvi;
        end else begin
            tmds_d = tmds_hdmi;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            state_q       <= ST_ACTIVE;
            active_mode_q <= RESET_MODE;
            target_q      <= RESET_MODE;
            stable_cnt_q  <= '0;
            mute_cnt_q    <= '0;
            tmds_q        <= blank_all;
        end else begin
            state_q       <= state_d;
            active_mode_q <= active_mode_d;
            target_q      <= target_d;
            stable_cnt_q  <= stable_cnt_d;
            mute_cnt_q    <= mute_cnt_d;
            tmds_q        <= tmds_d;
        end
    end

    assign tmds_channels = tmds_q;
    assign active_mode   = active_mode_q;
    assign dbg_state     = state_q;
    assign switching     = (state_q != ST_ACTIVE);

`ifdef TMDS_MODE_SWITCH_COUNT_EN
    logic [7:0] switch_count_q, switch_count_d;

    always_comb begin
        switch_count_d = switch_count_q;
        if ((active_mode_d != active_mode_q) && (switch_count_q != 8'hFF)) begin
            switch_count_d = switch_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            switch_count_q <= 8'd0;
        end else begin
            switch_count_q <= switch_count_d;
        end
    end

    assign switch_count = switch_count_q;
`endif

endmodule

// File: tb/tb_tmds_mode_switch.sv
// ----------------------------------------------------------------------------
// tb_tmds_mode_switch
//
// Two instances: dut_a with STABLE_FRAMES=2, MUTE_FRAMES=1 and dut_b with
// STABLE_FRAMES=1, MUTE_FRAMES=0. Each cycle is described by a table row
// holding the inputs and the expected outputs after that clock edge. Source
// symbols are randomised every cycle, so the expected output symbol is
// derived from the symbols driven in that cycle. This checks the one-cycle
// registered latency.
// ----------------------------------------------------------------------------
module tb_tmds_mode_switch;

    localparam int          NCH   = 3;
    localparam int          DW    = 10 * NCH;
    localparam logic [9:0]  BLANK = 10'b1101010100;
    localparam int          EW    = DW + 4;

    typedef struct packed {
        logic rst_n;
        logic req;
        logic fs;
        logic exp_mode;
        logic exp_sw;
        logic exp_blank;
    } row_t;

    logic          clk_pixel;
    logic [DW-1:0] tmds_hdmi, tmds_dvi;

    logic          rst_a, req_a, fs_a;
    logic [DW-1:0] out_a;
    logic          mode_a, sw_a;
    logic [1:0]    st_a;

    logic          rst_b, req_b, fs_b;
    logic [DW-1:0] out_b;
    logic          mode_b, sw_b;
    logic [1:0]    st_b;

`ifdef TMDS_MODE_SWITCH_COUNT_EN
    logic [7:0]    cnt_a, cnt_b;
`endif

    logic [EW-1:0] exp_q[$];
    int            n_cmp;
    int            n_err;

    row_t          tab_a[$];
    row_t          tab_b[$];

    tmds_mode_switch #(
        .NUM_CHANNELS(NCH), .STABLE_FRAMES(2), .MUTE_FRAMES(1),
        .RESET_MODE(1'b0), .BLANK_SYMBOL(BLANK)
    ) dut_a (
        .clk_pixel(clk_pixel), .reset_n(rst_a), .mode_req(req_a),
        .frame_start(fs_a), .tmds_hdmi(tmds_hdmi), .tmds_dvi(tmds_dvi),
        .tmds_channels(out_a), .active_mode(mode_a), .dbg_state(st_a),
        .switching(sw_a)
`ifdef TMDS_MODE_SWITCH_COUNT_EN
        , .switch_count(cnt_a)
`endif
    );

    tmds_mode_switch #(
        .NUM_CHANNELS(NCH), .STABLE_FRAMES(1), .MUTE_FRAMES(0),
        .RESET_MODE(1'b0), .BLANK_SYMBOL(BLANK)
    ) dut_b (
        .clk_pixel(clk_pixel), .reset_n(rst_b), .mode_req(req_b),
        .frame_start(fs_b), .tmds_hdmi(tmds_hdmi), .tmds_dvi(tmds_dvi),
        .tmds_channels(out_b), .active_mode(mode_b), .dbg_state(st_b),
        .switching(sw_b)
`ifdef TMDS_MODE_SWITCH_COUNT_EN
        , .switch_count(cnt_b)
`endif
    );

    // Clock / reset
    initial clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    function automatic row_t mk(input logic r, input logic q, input logic f,
                                input logic m, input logic s, input logic b);
        row_t t;
        t.rst_n = r; t.req = q; t.fs = f;
        t.exp_mode = m; t.exp_sw = s; t.exp_blank = b;
        return t;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Driver: one table row per clock. Expected outputs are pushed when the
    // row is driven and popped once the DUT has clocked it.
    task automatic step(input bit use_b, input row_t r);
        logic [DW-1:0] e_tmds;
        logic [1:0]    e_st;
        logic [EW-1:0] e;
        @(negedge clk_pixel);
        for (int c = 0; c < NCH; c++) begin
            tmds_hdmi[c*10 +: 10] = 10'($urandom_range(0, 1023));
            tmds_dvi[c*10 +: 10]  = 10'($urandom_range(0, 1023));
        end
        if (use_b) begin
            rst_b = r.rst_n; req_b = r.req; fs_b = r.fs;
        end else begin
            rst_a = r.rst_n; req_a = r.req; fs_a = r.fs;
        end
        if (r.exp_blank)     e_tmds = {NCH{BLANK}};
        else if (r.exp_mode) e_tmds = tmds_dvi;
        else                 e_tmds = tmds_hdmi;
        if (!r.exp_sw)         e_st = 2'd0;
        else if (r.exp_blank)  e_st = 2'd2;
        else                   e_st = 2'd1;
        exp_q.push_back({e_tmds, r.exp_mode, r.exp_sw, e_st});
        @(posedge clk_pixel);
        #1;
        e = exp_q.pop_front();
        if (use_b) begin
            check("b_tmds", out_b, DW'(e[EW-1:4]));
            check("b_active_mode", DW'(mode_b), DW'(e[3]));
            check("b_switching", DW'(sw_b), DW'(e[2]));
            check("b_state", DW'(st_b), DW'(e[1:0]));
        end else begin
            check("a_tmds", out_a, DW'(e[EW-1:4]));
            check("a_active_mode", DW'(mode_a), DW'(e[3]));
            check("a_switching", DW'(sw_a), DW'(e[2]));
            check("a_state", DW'(st_a), DW'(e[1:0]));
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_a = 1'b0; req_a = 1'b0; fs_a = 1'b0;
        rst_b = 1'b0; req_b = 1'b0; fs_b = 1'b0;
        tmds_hdmi = {NCH{10'h155}};
        tmds_dvi  = {NCH{10'h2AA}};

        // dut_a: STABLE_FRAMES=2, MUTE_FRAMES=1
        //                 rst req fs  mode sw blank
        tab_a.push_back(mk(0, 0, 0,  0, 0, 1)); // in reset: blank
        tab_a.push_back(mk(0, 0, 1,  0, 0, 1)); // reset wins over frame_start
        tab_a.push_back(mk(1, 0, 0,  0, 0, 0)); // HDMI right after release
        tab_a.push_back(mk(1, 1, 0,  0, 0, 0)); // request without frame start
        tab_a.push_back(mk(1, 1, 1,  0, 1, 0)); // fs#1 -> PENDING
        tab_a.push_back(mk(1, 1, 0,  0, 1, 0));
        tab_a.push_back(mk(1, 1, 1,  1, 1, 1)); // fs#2 -> switch, MUTE
        tab_a.push_back(mk(1, 1, 0,  1, 1, 1));
        tab_a.push_back(mk(1, 1, 1,  1, 0, 0)); // fs#3 -> DVI
        tab_a.push_back(mk(1, 1, 0,  1, 0, 0));
        tab_a.push_back(mk(1, 0, 1,  1, 1, 0)); // one-frame pulse to HDMI
        tab_a.push_back(mk(1, 1, 0,  1, 1, 0));
        tab_a.push_back(mk(1, 1, 1,  1, 0, 0)); // cancelled
        tab_a.push_back(mk(1, 1, 0,  1, 0, 0));
        tab_a.push_back(mk(0, 1, 0,  0, 0, 1)); // reset from DVI
        tab_a.push_back(mk(1, 0, 0,  0, 0, 0));
        tab_a.push_back(mk(1, 1, 1,  0, 1, 0)); // one-frame pulse to DVI
        tab_a.push_back(mk(1, 0, 0,  0, 1, 0));
        tab_a.push_back(mk(1, 0, 1,  0, 0, 0)); // cancelled
        tab_a.push_back(mk(1, 0, 1,  0, 0, 0));
        tab_a.push_back(mk(1, 1, 1,  0, 1, 0)); // PENDING
        tab_a.push_back(mk(1, 1, 1,  1, 1, 1)); // MUTE
        tab_a.push_back(mk(1, 0, 0,  1, 1, 1)); // request dropped in MUTE
        tab_a.push_back(mk(1, 0, 1,  1, 0, 0)); // mute completes in DVI
        tab_a.push_back(mk(1, 0, 0,  1, 0, 0));
        tab_a.push_back(mk(1, 0, 1,  1, 1, 0)); // switch back begins
        tab_a.push_back(mk(1, 0, 1,  0, 1, 1)); // MUTE towards HDMI
        tab_a.push_back(mk(0, 1, 1,  0, 0, 1)); // reset mid-MUTE
        tab_a.push_back(mk(1, 0, 1,  0, 0, 0));
        tab_a.push_back(mk(1, 1, 1,  0, 1, 0)); // PENDING
        tab_a.push_back(mk(0, 1, 1,  0, 0, 1)); // reset mid-PENDING
        tab_a.push_back(mk(1, 1, 0,  0, 0, 0));

        // dut_b: STABLE_FRAMES=1, MUTE_FRAMES=0
        tab_b.push_back(mk(0, 0, 0,  0, 0, 1));
        tab_b.push_back(mk(1, 0, 0,  0, 0, 0));
        tab_b.push_back(mk(1, 1, 0,  0, 0, 0));
        tab_b.push_back(mk(1, 1, 1,  1, 0, 0)); // immediate, no blank
        tab_b.push_back(mk(1, 1, 0,  1, 0, 0));
        tab_b.push_back(mk(1, 0, 1,  0, 0, 0)); // and straight back
        tab_b.push_back(mk(1, 0, 1,  0, 0, 0));

        foreach (tab_a[i]) step(1'b0, tab_a[i]);
        foreach (tab_b[i]) step(1'b1, tab_b[i]);

`ifdef TMDS_MODE_SWITCH_COUNT_EN
        // dut_a switched twice since its last reset, then was reset again.
        check("a_switch_count_after_reset", DW'(cnt_a), DW'(0));
        // dut_b: two switches since reset, then 300 back-to-back switches.
        check("b_switch_count_initial", DW'(cnt_b), DW'(2));
        begin
            int  exp_cnt;
            logic m;
            exp_cnt = 2;
            m = 1'b0;
            for (int i = 0; i < 300; i++) begin
                m = ~m;
                step(1'b1, mk(1, m, 1, m, 0, 0));
                if (exp_cnt < 255) exp_cnt++;
                check("b_switch_count", DW'(cnt_b), DW'(exp_cnt));
            end
            check("b_switch_count_saturated", DW'(cnt_b), DW'(255));
            step(1'b1, mk(0, 0, 0, 0, 0, 1));
            check("b_switch_count_reset", DW'(cnt_b), DW'(0));
        end
`endif

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tmds_mode_switch.md
# tmds_mode_switch

Glitch-free, frame-aligned selector between the free-running HDMI and DVI TMDS encoder outputs on the pixel clock. A mode change request must be debounced over whole frames. It takes effect only on a frame boundary and is bracketed by a configurable number of muted frames, so the sink re-locks cleanly. Sits between the two `hdmi` encoder instances and the serialiser, and supersedes the combinational `dvi_output` mux.

## Interface
- `NUM_CHANNELS`, 3: TMDS channels switched (1..4).
- `STABLE_FRAMES`, 2: consecutive frame starts the request must hold before switching (≥1).
- `MUTE_FRAMES`, 1: whole frames of blank symbol emitted during a switch (≥0).
- `RESET_MODE`, 0: mode after reset; 0 = HDMI, 1 = DVI.
- `BLANK_SYMBOL`, 10'b1101010100: symbol driven while muted or in reset (control period, C1C0=00).

- `clk_pixel`  in  1  pixel clock; the only clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `mode_req`  in  1  requested mode, 1 = DVI; may change on any cycle.
- `frame_start`  in  1  one-cycle pulse at cx=0, cy=0.
- `tmds_hdmi`  in  10 × NUM_CHANNELS  HDMI encoder symbols.
- `tmds_dvi`  in  10 × NUM_CHANNELS  DVI encoder symbols.
- `tmds_channels`  out  10 × NUM_CHANNELS  registered output symbols.
- `active_mode`  out  1  mode currently routed (1 = DVI).
- `switching`  out  1  high while a change is pending or muting.
- `switch_count`  out  8  completed switches (only with `TMDS_MODE_SWITCH_COUNT_EN`).

## Operation
- States: ACTIVE, PENDING, MUTE.
- ACTIVE:
  - `tmds_channels` follows the source selected by `active_mode`.
  - On `frame_start` with `mode_req != active_mode`: load the target (`target <= mode_req`), set stable_cnt=1, and go to PENDING.
- PENDING:
  - Output still follows `active_mode`.
  - On each `frame_start`:
    - `mode_req == active_mode`: go to ACTIVE (cancel).
    - `mode_req != target`: reload the target and set stable_cnt=1. This case is unreachable with a 1-bit mode, but the count is defined this way for parameter widening.
    - Otherwise: stable_cnt += 1.
  - When stable_cnt reaches STABLE_FRAMES on a `frame_start`:
    - `active_mode <= target` in the same cycle.
    - If MUTE_FRAMES>0: go to MUTE with mute_cnt=MUTE_FRAMES.
    - Else: go to ACTIVE. The frame beginning at that pulse uses the new source.
- MUTE:
  - All channels are driven with BLANK_SYMBOL.
  - Each `frame_start` decrements mute_cnt. The pulse that takes it to 0 returns the block to ACTIVE, and the new source appears for that frame.
  - `mode_req` is ignored while in MUTE and is re-evaluated on the first `frame_start` after returning to ACTIVE (the next frame).
- `frame_start` is only sampled, never counted, outside the cases above.
- Counter widths: `$clog2(STABLE_FRAMES+1)` and `$clog2(MUTE_FRAMES+1)`. No wrap is possible.
- `switching` = (state != ACTIVE).

## Timing
- `tmds_channels` has 1-cycle latency from the inputs and the state; it is registered after selection.
- A switch decided on a `frame_start` in cycle N first shows BLANK_SYMBOL, or the new source, at the output in cycle N+1. This aligns with the encoder's pixel 0 of that frame, delayed by 1.
- `active_mode` and `switching` update in the cycle after the deciding `frame_start`.
- Reset (`reset_n`=0 at a clk edge) values:
  - `tmds_channels` = BLANK_SYMBOL on all channels.
  - `active_mode` = RESET_MODE.
  - `switching` = 0, state = ACTIVE, counters = 0.
  - `switch_count` = 0.
- Reset wins over a simultaneous `frame_start`. Reset asserted mid-PENDING or mid-MUTE aborts the switch to RESET_MODE.
- First cycle after reset release: output follows the RESET_MODE source.
- Minimum request-to-switch latency: STABLE_FRAMES frame starts. Worst case adds one frame for the first sample.

## Configuration
- `TMDS_MODE_SWITCH_COUNT_EN` defined:
  - `switch_count` port exists.
  - It increments, saturating at 255, in the cycle `active_mode` changes.
- Undefined: port and counter are omitted; all other behaviour is identical.

## Test plan
- Reset, RESET_MODE=0, source symbols 10'h155 (HDMI) / 10'h2AA (DVI):
  - `tmds_channels`=10'h354 during reset.
  - 10'h155 on the cycle after release.
  - `switching`=0.
- `mode_req`=1 held, STABLE_FRAMES=2, MUTE_FRAMES=1:
  - `switching` rises after frame_start #1.
  - Output is BLANK from frame_start #2+1 cycle.
  - Output is 10'h2AA from frame_start #3+1 cycle.
  - `active_mode`=1 after #2.
- `mode_req` pulses to 1 for one frame only (STABLE_FRAMES=2):
  - PENDING is cancelled at the next `frame_start`.
  - Output never leaves 10'h155; `active_mode` stays 0.
- MUTE_FRAMES=0, STABLE_FRAMES=1: output switches 10'h155→10'h2AA exactly one cycle after the first `frame_start` seeing `mode_req`=1, with no BLANK cycles.
- `mode_req` toggled back to 0 during MUTE:
  - The mute completes in DVI.
  - A new switch back to HDMI begins on the following frame.
  - `reset_n`=0 mid-MUTE forces HDMI with `switching`=0.
- With `TMDS_MODE_SWITCH_COUNT_EN`, 300 alternating switches: `switch_count` saturates at 255.
